// File: rtl/store_align_unit_pkg.sv
// Shared types for the MEM-stage store path: operation encoding, bus types,
// write-beat record and the store FSM state encoding.
package store_align_unit_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  mask_t;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_enum;

  typedef struct packed {
    addr_t addr;
    data_t wdata;
    mask_t wmask;
  } mem_beat_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ0 = 3'd1,
    ST_ACK0 = 3'd2,
    ST_REQ1 = 3'd3,
    ST_ACK1 = 3'd4
  } store_state_e;

  // Signed and unsigned variants occupy the same number of bytes in memory.
  function automatic logic [3:0] mem_size(mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: return 4'd1;
      MEM_H, MEM_UH: return 4'd2;
      MEM_W, MEM_UW: return 4'd4;
      MEM_D:         return 4'd8;
      default:       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane placement: moves a right-justified store value and its
// byte mask to the byte offset within a 16-byte (two-beat) window.
module store_lane_shift
  import store_align_unit_pkg::*;
(
  input  data_t          st_data,
  input  mem_op_enum     st_op,
  input  logic [2:0]     off,
  output logic [127:0]   wide_data,
  output logic [15:0]    wide_mask
);

  mask_t base_mask;

  always_comb begin
    base_mask = 8'h00;
    case (mem_size(st_op))
      4'd1:    base_mask = 8'h01;
      4'd2:    base_mask = 8'h03;
      4'd4:    base_mask = 8'h0F;
      4'd8:    base_mask = 8'hFF;
      default: base_mask = 8'h00;
    endcase
  end

  // Bytes above the access size are shifted along but never enabled.
  assign wide_data = {64'b0, st_data} << {off, 3'b000};
  assign wide_mask = {8'b0, base_mask} << off;

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: places a store on the 64-bit bus, splits 8-byte
// boundary crossings into two beats and reports completion after all acks.
//
// state | meaning
// IDLE  | ready for a request; st_done/st_err pulse here after completion
// REQ0  | first beat offered, waiting for mem_req_ready
// ACK0  | first beat accepted, waiting for its write acknowledge
// REQ1  | second beat of a crossing store offered
// ACK1  | second beat accepted, waiting for its write acknowledge
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  addr_t       st_addr,
  input  data_t       st_data,
  input  mem_op_enum  st_op,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output addr_t       mem_addr,
  output data_t       mem_wdata,
  output mask_t       mem_wmask,
  input  logic        mem_resp_valid
);

  store_state_e state;
  mem_beat_t    out_beat;
  mem_beat_t    pend_beat;
  mem_beat_t    nxt0;
  mem_beat_t    nxt1;
  logic         has_beat1;
  logic [127:0] wide_data;
  logic [15:0]  wide_mask;
  logic         crossing;

  store_lane_shift u_lane_shift (
    .st_data   (st_data),
    .st_op     (st_op),
    .off       (st_addr[2:0]),
    .wide_data (wide_data),
    .wide_mask (wide_mask)
  );

  always_comb begin
    nxt0.addr  = {st_addr[63:3], 3'b000};
    nxt0.wdata = wide_data[63:0];
    nxt0.wmask = wide_mask[7:0];
    nxt1.addr  = nxt0.addr + 64'd8;
    nxt1.wdata = wide_data[127:64];
    nxt1.wmask = wide_mask[15:8];
  end

  assign crossing  = |wide_mask[15:8];
  assign st_ready  = (state == ST_IDLE);
  assign mem_addr  = out_beat.addr;
  assign mem_wdata = out_beat.wdata;
  assign mem_wmask = out_beat.wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      st_done       <= 1'b0;
      st_err        <= 1'b0;
      mem_req_valid <= 1'b0;
      out_beat      <= '0;
      pend_beat     <= '0;
      has_beat1     <= 1'b0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (st_valid) begin
            pend_beat <= nxt1;
            has_beat1 <= crossing;
            if (st_op == MEM_NO) begin
              st_done <= 1'b1;
            end else if (crossing && !ALLOW_SPLIT) begin
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else begin
              out_beat      <= nxt0;
              mem_req_valid <= 1'b1;
              state         <= ST_REQ0;
            end
          end
        end
        ST_REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_ACK0;
          end
        end
        ST_ACK0: begin
          if (mem_resp_valid) begin
            if (has_beat1) begin
              out_beat      <= pend_beat;
              mem_req_valid <= 1'b1;
              state         <= ST_REQ1;
            end else begin
              st_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (mem_resp_valid) begin
            st_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: one splitting and one rejecting
// instance share the stimulus; expected values are hand-computed constants.
module tb_store_align_unit;
  import store_align_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       st_valid;
  addr_t      st_addr;
  data_t      st_data;
  mem_op_enum st_op;
  logic       mem_req_ready;
  logic       mem_resp_valid;

  logic  st_ready_a, st_done_a, st_err_a, mem_req_valid_a;
  addr_t mem_addr_a;
  data_t mem_wdata_a;
  mask_t mem_wmask_a;
  logic  st_ready_b, st_done_b, st_err_b, mem_req_valid_b;
  addr_t mem_addr_b;
  data_t mem_wdata_b;
  mask_t mem_wmask_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_align_unit #(.ALLOW_SPLIT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready_a),
    .st_addr(st_addr), .st_data(st_data), .st_op(st_op),
    .st_done(st_done_a), .st_err(st_err_a),
    .mem_req_valid(mem_req_valid_a), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wmask(mem_wmask_a),
    .mem_resp_valid(mem_resp_valid)
  );

  store_align_unit #(.ALLOW_SPLIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready_b),
    .st_addr(st_addr), .st_data(st_data), .st_op(st_op),
    .st_done(st_done_b), .st_err(st_err_b),
    .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wmask(mem_wmask_b),
    .mem_resp_valid(mem_resp_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic accept(input mem_op_enum op, input addr_t addr, input data_t data);
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    st_valid = 1'b1;
    check_eq("accept_ready", 64'(st_ready_a), 64'd1);
    step();
    st_valid = 1'b0;
  endtask

  // Single-beat store with ready held high and an ack one cycle after handshake.
  task automatic run_single(input string tag, input addr_t exp_addr, input mask_t exp_mask,
                            input data_t lane, input data_t exp_lane);
    check_eq({tag, "_valid"}, 64'(mem_req_valid_a), 64'd1);
    check_eq({tag, "_addr"}, mem_addr_a, exp_addr);
    check_eq({tag, "_mask"}, 64'(mem_wmask_a), 64'(exp_mask));
    check_eq({tag, "_wdata"}, mem_wdata_a & lane, exp_lane);
    check_eq({tag, "_done_t1"}, 64'(st_done_a), 64'd0);
    step();
    check_eq({tag, "_valid_ack"}, 64'(mem_req_valid_a), 64'd0);
    check_eq({tag, "_done_t2"}, 64'(st_done_a), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq({tag, "_done_t3"}, 64'(st_done_a), 64'd1);
    check_eq({tag, "_err"}, 64'(st_err_a), 64'd0);
    check_eq({tag, "_ready_t3"}, 64'(st_ready_a), 64'd1);
    step();
    check_eq({tag, "_done_pulse"}, 64'(st_done_a), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    st_valid       = 1'b0;
    st_addr        = '0;
    st_data        = '0;
    st_op          = MEM_NO;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    step();
    step();
    check_eq("rst_done", 64'(st_done_a), 64'd0);
    check_eq("rst_err", 64'(st_err_a), 64'd0);
    check_eq("rst_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("rst_mask", 64'(mem_wmask_a), 64'd0);
    check_eq("rst_addr", mem_addr_a, 64'd0);
    check_eq("rst_wdata", mem_wdata_a, 64'd0);
    check_eq("rst_ready", 64'(st_ready_a), 64'd1);
    rst = 1'b0;
    step();

    // SD aligned doubleword
    mem_req_ready = 1'b1;
    accept(MEM_D, 64'h1000, 64'h1122334455667788);
    run_single("sd", 64'h1000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122334455667788);

    // SB at offset 3, upper bytes must be gated by the mask
    accept(MEM_B, 64'h2003, 64'hFFFF_FFFF_FFFF_FFAB);
    run_single("sb", 64'h2000, 8'h08, 64'h0000_0000_FF00_0000, 64'h0000_0000_AB00_0000);

    // SW crossing: split on dut_a, rejected on dut_b
    accept(MEM_W, 64'h3006, 64'h0000_0000_DEAD_BEEF);
    check_eq("sw_b0_valid", 64'(mem_req_valid_a), 64'd1);
    check_eq("sw_b0_addr", mem_addr_a, 64'h3000);
    check_eq("sw_b0_mask", 64'(mem_wmask_a), 64'hC0);
    check_eq("sw_b0_wdata", mem_wdata_a & 64'hFFFF_0000_0000_0000, 64'hBEEF_0000_0000_0000);
    check_eq("rej_valid", 64'(mem_req_valid_b), 64'd0);
    check_eq("rej_done", 64'(st_done_b), 64'd1);
    check_eq("rej_err", 64'(st_err_b), 64'd1);
    step();
    check_eq("sw_ack0_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("rej_done_pulse", 64'(st_done_b), 64'd0);
    check_eq("rej_err_pulse", 64'(st_err_b), 64'd0);
    check_eq("rej_valid_t2", 64'(mem_req_valid_b), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq("sw_b1_valid", 64'(mem_req_valid_a), 64'd1);
    check_eq("sw_b1_addr", mem_addr_a, 64'h3008);
    check_eq("sw_b1_mask", 64'(mem_wmask_a), 64'h03);
    check_eq("sw_b1_wdata", mem_wdata_a & 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_DEAD);
    check_eq("sw_done_mid", 64'(st_done_a), 64'd0);
    check_eq("rej_valid_t3", 64'(mem_req_valid_b), 64'd0);
    step();
    check_eq("sw_ack1_valid", 64'(mem_req_valid_a), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq("sw_done", 64'(st_done_a), 64'd1);
    check_eq("sw_err", 64'(st_err_a), 64'd0);
    step();
    check_eq("sw_done_pulse", 64'(st_done_a), 64'd0);

    // Stray ack in IDLE, then SH with a 5-cycle ready stall
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq("stray_done", 64'(st_done_a), 64'd0);
    check_eq("stray_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("stray_ready", 64'(st_ready_a), 64'd1);
    mem_req_ready = 1'b0;
    accept(MEM_H, 64'h4002, 64'h0000_0000_CAFE_5A5A);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("sh_valid_%0d", i), 64'(mem_req_valid_a), 64'd1);
      check_eq($sformatf("sh_addr_%0d", i), mem_addr_a, 64'h4000);
      check_eq($sformatf("sh_mask_%0d", i), 64'(mem_wmask_a), 64'h0C);
      check_eq($sformatf("sh_wdata_%0d", i), mem_wdata_a, 64'h0000_CAFE_5A5A_0000);
      if (i == 4) mem_req_ready = 1'b1;
      step();
    end
    check_eq("sh_ack_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("sh_ack_done", 64'(st_done_a), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq("sh_done", 64'(st_done_a), 64'd1);
    step();

    // Reset while waiting for the first ack of a split store
    accept(MEM_W, 64'h3006, 64'h0000_0000_DEAD_BEEF);
    step();
    check_eq("rr_in_ack0", 64'(mem_req_valid_a), 64'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("rr_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("rr_mask", 64'(mem_wmask_a), 64'd0);
    check_eq("rr_addr", mem_addr_a, 64'd0);
    check_eq("rr_wdata", mem_wdata_a, 64'd0);
    check_eq("rr_done", 64'(st_done_a), 64'd0);
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check_eq("rr_late_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("rr_late_done", 64'(st_done_a), 64'd0);
    step();
    check_eq("rr_late_valid2", 64'(mem_req_valid_a), 64'd0);
    check_eq("rr_late_done2", 64'(st_done_a), 64'd0);

    // MEM_NO completes without memory traffic
    accept(MEM_NO, 64'h5000, 64'h0);
    check_eq("no_done", 64'(st_done_a), 64'd1);
    check_eq("no_err", 64'(st_err_a), 64'd0);
    check_eq("no_valid", 64'(mem_req_valid_a), 64'd0);
    check_eq("no_err_b", 64'(st_err_b), 64'd0);
    step();
    check_eq("no_done_pulse", 64'(st_done_a), 64'd0);
    check_eq("no_valid2", 64'(mem_req_valid_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
